// File: rtl/pe_array_feeder.sv
// Input-side sequencer for the 5x4 LeNet PE array: loads one 5x5 kernel, then streams
// GROUPS four-row map groups, each followed by a flush-and-drain window on dinVld.
module pe_array_feeder #(
  parameter int DATA_SIZE = 8,
  parameter int K         = 5,
  parameter int IMG_W     = 32,
  parameter int GROUPS    = 7,
  parameter int DRAIN_CYC = 4,
  parameter int MA_W      = 8
) (
  input  logic                   clk_cal,
  input  logic                   rst_cal,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic [5*DATA_SIZE-1:0] bias_in,
  output logic                   w_rd_en,
  output logic [4:0]             w_addr,
  input  logic [DATA_SIZE-1:0]   w_rdata,
  output logic                   m_rd_en,
  output logic [MA_W-1:0]        m_addr,
  input  logic [4*DATA_SIZE-1:0] m_rdata,
  output logic [DATA_SIZE-1:0]   IWeight0, IWeight1, IWeight2, IWeight3, IWeight4,
  output logic                   IweightVld0, IweightVld1, IweightVld2, IweightVld3, IweightVld4,
  output logic [DATA_SIZE-1:0]   IMap0, IMap1, IMap2, IMap3,
  output logic                   ImapVld0, ImapVld1, ImapVld2, ImapVld3,
  output logic [DATA_SIZE-1:0]   bias0, bias1, bias2, bias3, bias4,
  output logic                   dinVld,
  output logic [2:0]             dbg_state
);
  localparam int DRAIN_LEN = 2 + DRAIN_CYC;
  localparam int GW = $clog2(GROUPS + 1);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int DW = $clog2(DRAIN_LEN);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FIN} state_t;

  // Handshake: none. start is a one-cycle request sampled only in IDLE; both buffers
  // answer a read enable with data exactly one cycle later, and nothing can stall.
  state_t                 state;
  logic [1:0]             rst_pipe;
  logic                   rst_n;
  logic [2:0]             k_row, k_col;
  logic [XW-1:0]          x_cnt;
  logic [DW-1:0]          d_cnt;
  logic [GW-1:0]          g_cnt;
  logic [5*DATA_SIZE-1:0] bias_q;
  logic                   w_vld_d, m_vld_d;
  logic [2:0]             w_sel_d;
  logic [DATA_SIZE-1:0]   iweight [K];
  logic [K-1:0]           iweight_vld;
  logic [DATA_SIZE-1:0]   imap [4];
  logic                   imap_vld;

  // Asserts immediately with rst_cal, releases two clocks after it rises.
  always_ff @(posedge clk_cal or negedge rst_cal) begin
    if (!rst_cal) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  always_ff @(posedge clk_cal or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      w_rd_en <= 1'b0;
      m_rd_en <= 1'b0;
      dinVld  <= 1'b0;
      w_addr  <= '0;
      m_addr  <= '0;
      k_row   <= '0;
      k_col   <= '0;
      x_cnt   <= '0;
      d_cnt   <= '0;
      g_cnt   <= '0;
      bias_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= LOAD_W;
          busy    <= 1'b1;
          w_rd_en <= 1'b1;
          w_addr  <= '0;
          k_row   <= '0;
          k_col   <= '0;
          g_cnt   <= '0;
          bias_q  <= bias_in;
        end
        LOAD_W: begin
          if (w_addr == 5'd24) begin
            state   <= STREAM;
            w_rd_en <= 1'b0;
            m_rd_en <= 1'b1;
            m_addr  <= '0;
            x_cnt   <= '0;
          end else begin
            w_addr <= w_addr + 1'b1;
            // k_row tracks the kernel row of w_addr, i.e. the destination column.
            if (k_col == 3'd4) begin
              k_col <= '0;
              k_row <= k_row + 1'b1;
            end else begin
              k_col <= k_col + 1'b1;
            end
          end
        end
        STREAM: begin
          if (x_cnt == XW'(IMG_W - 1)) begin
            state   <= DRAIN;
            m_rd_en <= 1'b0;
            d_cnt   <= '0;
          end else begin
            x_cnt  <= x_cnt + 1'b1;
            m_addr <= m_addr + 1'b1;
          end
        end
        DRAIN: begin
          d_cnt <= d_cnt + 1'b1;
          if (d_cnt == DW'(1)) dinVld <= 1'b1;
          if (d_cnt == DW'(DRAIN_LEN - 1)) begin
            dinVld <= 1'b0;
            g_cnt  <= g_cnt + 1'b1;
            if (g_cnt == GW'(GROUPS - 1)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              // Groups are contiguous in the map buffer, so the address simply continues.
              state   <= STREAM;
              m_rd_en <= 1'b1;
              m_addr  <= m_addr + 1'b1;
              x_cnt   <= '0;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: buffer data (arriving one cycle after the read) is registered here.
  always_ff @(posedge clk_cal or negedge rst_n) begin
    if (!rst_n) begin
      w_vld_d     <= 1'b0;
      m_vld_d     <= 1'b0;
      w_sel_d     <= '0;
      iweight_vld <= '0;
      imap_vld    <= 1'b0;
      for (int c = 0; c < K; c++) iweight[c] <= '0;
      for (int r = 0; r < 4; r++) imap[r] <= '0;
    end else begin
      w_vld_d     <= w_rd_en;
      w_sel_d     <= k_row;
      m_vld_d     <= m_rd_en;
      iweight_vld <= '0;
      imap_vld    <= m_vld_d;
      if (w_vld_d) begin
        iweight[w_sel_d]     <= w_rdata;
        iweight_vld[w_sel_d] <= 1'b1;
      end
      if (m_vld_d) begin
        for (int r = 0; r < 4; r++) imap[r] <= m_rdata[DATA_SIZE*r +: DATA_SIZE];
      end
    end
  end

  assign IWeight0 = iweight[0];
  assign IWeight1 = iweight[1];
  assign IWeight2 = iweight[2];
  assign IWeight3 = iweight[3];
  assign IWeight4 = iweight[4];
  assign {IweightVld4, IweightVld3, IweightVld2, IweightVld1, IweightVld0} = iweight_vld;
  assign IMap0 = imap[0];
  assign IMap1 = imap[1];
  assign IMap2 = imap[2];
  assign IMap3 = imap[3];
  assign {ImapVld3, ImapVld2, ImapVld1, ImapVld0} = {4{imap_vld}};
  assign bias0 = bias_q[0*DATA_SIZE +: DATA_SIZE];
  assign bias1 = bias_q[1*DATA_SIZE +: DATA_SIZE];
  assign bias2 = bias_q[2*DATA_SIZE +: DATA_SIZE];
  assign bias3 = bias_q[3*DATA_SIZE +: DATA_SIZE];
  assign bias4 = bias_q[4*DATA_SIZE +: DATA_SIZE];
  assign dbg_state = state;
endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder: cycle-exact checks of kernel load, map streaming,
// full job timing, ignored mid-job start, bias latching and mid-job reset.
module tb_pe_array_feeder;
  logic        clk_cal = 1'b0;
  logic        rst_cal;
  logic        start;
  logic        busy, done;
  logic [39:0] bias_in;
  logic        w_rd_en;
  logic [4:0]  w_addr;
  logic [7:0]  w_rdata;
  logic        m_rd_en;
  logic [7:0]  m_addr;
  logic [31:0] m_rdata;
  logic [7:0]  IWeight0, IWeight1, IWeight2, IWeight3, IWeight4;
  logic        IweightVld0, IweightVld1, IweightVld2, IweightVld3, IweightVld4;
  logic [7:0]  IMap0, IMap1, IMap2, IMap3;
  logic        ImapVld0, ImapVld1, ImapVld2, ImapVld3;
  logic [7:0]  bias0, bias1, bias2, bias3, bias4;
  logic        dinVld;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int rel   = 0;

  pe_array_feeder dut (
    .clk_cal(clk_cal), .rst_cal(rst_cal), .start(start), .busy(busy), .done(done),
    .bias_in(bias_in), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .m_rd_en(m_rd_en), .m_addr(m_addr), .m_rdata(m_rdata),
    .IWeight0(IWeight0), .IWeight1(IWeight1), .IWeight2(IWeight2), .IWeight3(IWeight3),
    .IWeight4(IWeight4),
    .IweightVld0(IweightVld0), .IweightVld1(IweightVld1), .IweightVld2(IweightVld2),
    .IweightVld3(IweightVld3), .IweightVld4(IweightVld4),
    .IMap0(IMap0), .IMap1(IMap1), .IMap2(IMap2), .IMap3(IMap3),
    .ImapVld0(ImapVld0), .ImapVld1(ImapVld1), .ImapVld2(ImapVld2), .ImapVld3(ImapVld3),
    .bias0(bias0), .bias1(bias1), .bias2(bias2), .bias3(bias3), .bias4(bias4),
    .dinVld(dinVld), .dbg_state(dbg_state)
  );

  always #5 clk_cal = ~clk_cal;

  logic [4:0] wvld;
  logic [3:0] mvld;
  logic [7:0] iw [5];
  assign wvld = {IweightVld4, IweightVld3, IweightVld2, IweightVld1, IweightVld0};
  assign mvld = {ImapVld3, ImapVld2, ImapVld1, ImapVld0};
  assign iw[0] = IWeight0;
  assign iw[1] = IWeight1;
  assign iw[2] = IWeight2;
  assign iw[3] = IWeight3;
  assign iw[4] = IWeight4;

  // Buffer models: w[a] = a+1; map word at g*32+x = {g, x, x+1, x+2}.
  always @(posedge clk_cal) begin
    if (w_rd_en) w_rdata <= 8'(w_addr) + 8'd1;
    if (m_rd_en) m_rdata <= {8'(m_addr / 32), 8'(m_addr % 32), 8'(m_addr % 32 + 1),
                             8'(m_addr % 32 + 2)};
  end

  task automatic next_cycle();
    @(posedge clk_cal);
    #1;
    cyc++;
    rel   = cyc - t0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (i == 3) rst_cal = 1'b1;
      @(negedge clk_cal);
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
      total++; if (w_rd_en !== 1'b0 || m_rd_en !== 1'b0 || dinVld !== 1'b0) begin bad++; $display("FAIL reset_enables got=%b%b%b want=000", w_rd_en, m_rd_en, dinVld); end
      total++; if (wvld !== 5'b0 || mvld !== 4'b0) begin bad++; $display("FAIL reset_valids got=%b/%b want=0", wvld, mvld); end
      total++; if (bias0 !== 8'd0 || bias4 !== 8'd0 || IWeight0 !== 8'd0 || IMap0 !== 8'd0) begin bad++; $display("FAIL reset_data got=%h %h %h %h want=0", bias0, bias4, IWeight0, IMap0); end
      total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    end
  endtask

  task automatic test_weight_load();
    logic [4:0] ev;
    int col;
    bias_in = 40'h0504030201;
    next_cycle();
    t0 = cyc; rel = 0; start = 1'b1;
    @(negedge clk_cal);
    while (rel < 27) begin
      next_cycle();
      @(negedge clk_cal);
      total++; if (w_rd_en !== (rel <= 25)) begin bad++; $display("FAIL w_rd_en rel=%0d got=%b want=%b", rel, w_rd_en, rel <= 25); end
      if (rel <= 25) begin
        total++; if (w_addr !== 5'(rel - 1)) begin bad++; $display("FAIL w_addr rel=%0d got=%0d want=%0d", rel, w_addr, rel - 1); end
      end
      ev = 5'b0; col = 0;
      if (rel >= 3) begin col = (rel - 3) / 5; ev = 5'b1 << col; end
      total++; if (wvld !== ev) begin bad++; $display("FAIL wvld rel=%0d got=%b want=%b", rel, wvld, ev); end
      if (rel >= 3) begin
        total++; if (iw[col] !== 8'(rel - 2)) begin bad++; $display("FAIL iweight rel=%0d col=%0d got=%0d want=%0d", rel, col, iw[col], rel - 2); end
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL load_busy rel=%0d got=%b want=1", rel, busy); end
      if (rel >= 26) begin
        total++; if (m_rd_en !== 1'b1 || m_addr !== 8'(rel - 26)) begin bad++; $display("FAIL first_read rel=%0d got=%b/%0d want=1/%0d", rel, m_rd_en, m_addr, rel - 26); end
      end
      if (rel == 1) begin
        total++; if ({bias4, bias3, bias2, bias1, bias0} !== 40'h0504030201) begin bad++; $display("FAIL bias_latch got=%h want=0504030201", {bias4, bias3, bias2, bias1, bias0}); end
      end
    end
  endtask

  task automatic test_map_stream();
    logic [7:0] x;
    while (rel < 64) begin
      next_cycle();
      @(negedge clk_cal);
      total++; if (m_rd_en !== (rel <= 57 || rel == 64)) begin bad++; $display("FAIL m_rd_en rel=%0d got=%b", rel, m_rd_en); end
      if (rel <= 57) begin
        total++; if (m_addr !== 8'(rel - 26)) begin bad++; $display("FAIL m_addr rel=%0d got=%0d want=%0d", rel, m_addr, rel - 26); end
      end
      total++; if (mvld !== {4{rel <= 59}}) begin bad++; $display("FAIL mvld rel=%0d got=%b want=%b", rel, mvld, rel <= 59); end
      x = (rel <= 59) ? 8'(rel - 28) : 8'd31;
      total++; if (IMap0 !== x + 8'd2 || IMap1 !== x + 8'd1 || IMap2 !== x || IMap3 !== 8'd0) begin bad++; $display("FAIL imap rel=%0d got=%0d,%0d,%0d,%0d want=%0d,%0d,%0d,0", rel, IMap0, IMap1, IMap2, IMap3, x + 2, x + 1, x); end
      total++; if (dinVld !== (rel >= 60 && rel <= 63)) begin bad++; $display("FAIL din_vld rel=%0d got=%b", rel, dinVld); end
      total++; if (wvld !== 5'b0 || IWeight4 !== 8'd25 || IWeight0 !== 8'd5) begin bad++; $display("FAIL weight_hold rel=%0d got=%b %0d %0d want=0 25 5", rel, wvld, IWeight4, IWeight0); end
      if (rel == 64) begin
        total++; if (m_addr !== 8'd32) begin bad++; $display("FAIL group1_addr got=%0d want=32", m_addr); end
      end
    end
  endtask

  task automatic test_start_ignored();
    int gi, p;
    while (rel < 130) begin
      next_cycle();
      if (rel == 100) begin start = 1'b1; bias_in = 40'hAABBCCDDEE; end
      @(negedge clk_cal);
      gi = (rel - 26) / 38; p = (rel - 26) % 38;
      total++; if (w_rd_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ign_ctrl rel=%0d got=%b%b want=01", rel, w_rd_en, busy); end
      total++; if (m_rd_en !== (p < 32)) begin bad++; $display("FAIL ign_rd rel=%0d got=%b want=%b", rel, m_rd_en, p < 32); end
      if (p < 32) begin
        total++; if (m_addr !== 8'(32 * gi + p)) begin bad++; $display("FAIL ign_addr rel=%0d got=%0d want=%0d", rel, m_addr, 32 * gi + p); end
      end
      total++; if ({bias4, bias3, bias2, bias1, bias0} !== 40'h0504030201) begin bad++; $display("FAIL ign_bias rel=%0d got=%h want=0504030201", rel, {bias4, bias3, bias2, bias1, bias0}); end
    end
  endtask

  task automatic test_full_job();
    int gi, p, gr, xr;
    logic rd, mv, din;
    while (rel < 300) begin
      next_cycle();
      @(negedge clk_cal);
      gi = (rel - 26) / 38; p = (rel - 26) % 38;
      gr = (rel - 28) / 38; xr = (rel - 28) % 38;
      rd  = (gi < 7) && (p < 32);
      din = (gi < 7) && (p >= 34);
      mv  = (gr < 7) && (xr < 32);
      total++; if (m_rd_en !== rd) begin bad++; $display("FAIL job_rd rel=%0d got=%b want=%b", rel, m_rd_en, rd); end
      if (rd) begin
        total++; if (m_addr !== 8'(32 * gi + p)) begin bad++; $display("FAIL job_addr rel=%0d got=%0d want=%0d", rel, m_addr, 32 * gi + p); end
      end
      total++; if (mvld !== {4{mv}}) begin bad++; $display("FAIL job_mvld rel=%0d got=%b want=%b", rel, mvld, mv); end
      if (mv) begin
        total++; if (IMap3 !== 8'(gr) || IMap0 !== 8'(xr + 2)) begin bad++; $display("FAIL job_imap rel=%0d got=%0d,%0d want=%0d,%0d", rel, IMap3, IMap0, gr, xr + 2); end
      end
      total++; if (dinVld !== din) begin bad++; $display("FAIL job_din rel=%0d got=%b want=%b", rel, dinVld, din); end
      total++; if (done !== (rel == 292)) begin bad++; $display("FAIL job_done rel=%0d got=%b want=%b", rel, done, rel == 292); end
      total++; if (busy !== (rel <= 292)) begin bad++; $display("FAIL job_busy rel=%0d got=%b want=%b", rel, busy, rel <= 292); end
      total++; if (w_rd_en !== 1'b0) begin bad++; $display("FAIL job_wrd rel=%0d got=%b want=0", rel, w_rd_en); end
      if (rel == 285) begin
        total++; if (m_addr !== 8'd223) begin bad++; $display("FAIL last_addr got=%0d want=223", m_addr); end
      end
      if (rel == 300) begin
        total++; if (dbg_state !== 3'd0 || bias2 !== 8'd3) begin bad++; $display("FAIL job_end got=%0d/%0d want=0/3", dbg_state, bias2); end
      end
    end
  endtask

  task automatic test_reset_mid_job();
    bias_in = 40'h0A0B0C0D0E;
    next_cycle();
    t0 = cyc; rel = 0; start = 1'b1;
    @(negedge clk_cal);
    while (rel < 52) begin
      next_cycle();
      if (rel == 40) rst_cal = 1'b0;
      if (rel == 41) rst_cal = 1'b1;
      if (rel == 45) start = 1'b1;
      @(negedge clk_cal);
      if (rel == 39) begin
        total++; if (m_rd_en !== 1'b1 || m_addr !== 8'd13 || mvld !== 4'hf || bias0 !== 8'h0E) begin bad++; $display("FAIL pre_reset got=%b %0d %b %h want=1 13 f 0e", m_rd_en, m_addr, mvld, bias0); end
      end
      if (rel == 40) begin
        total++; if (busy !== 1'b0 || done !== 1'b0 || w_rd_en !== 1'b0 || m_rd_en !== 1'b0) begin bad++; $display("FAIL rst_ctrl got=%b%b%b%b want=0000", busy, done, w_rd_en, m_rd_en); end
        total++; if (wvld !== 5'b0 || mvld !== 4'b0 || dinVld !== 1'b0) begin bad++; $display("FAIL rst_valids got=%b %b %b want=0", wvld, mvld, dinVld); end
        total++; if (bias0 !== 8'd0 || bias4 !== 8'd0) begin bad++; $display("FAIL rst_bias got=%h %h want=0", bias0, bias4); end
      end
      if (rel >= 41 && rel <= 45) begin
        total++; if (busy !== 1'b0 || m_rd_en !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_idle rel=%0d got=%b%b%b want=000", rel, busy, m_rd_en, done); end
      end
      if (rel >= 46) begin
        total++; if (busy !== 1'b1 || w_rd_en !== 1'b1 || w_addr !== 5'(rel - 46)) begin bad++; $display("FAIL restart rel=%0d got=%b%b %0d want=11 %0d", rel, busy, w_rd_en, w_addr, rel - 46); end
      end
      if (rel == 46) begin
        total++; if (bias0 !== 8'h0E || bias4 !== 8'h0A) begin bad++; $display("FAIL restart_bias got=%h %h want=0e 0a", bias0, bias4); end
      end
      if (rel == 48) begin
        total++; if (wvld !== 5'b00001 || IWeight0 !== 8'd1) begin bad++; $display("FAIL restart_weight got=%b %0d want=00001 1", wvld, IWeight0); end
      end
    end
  endtask

  initial begin
    rst_cal = 1'b0;
    start   = 1'b0;
    bias_in = '0;
    test_reset();
    test_weight_load();
    test_map_stream();
    test_start_ignored();
    test_full_job();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
